// File: rtl/memory_access_unit_pkg.sv
// Shared encodings for the memory stage: funct3 access sizes, ResultSrc selects,
// FSM states and the memory/writeback register layout.
package memory_access_unit_pkg;

  localparam logic [2:0] F3_BYTE  = 3'b000;
  localparam logic [2:0] F3_HALF  = 3'b001;
  localparam logic [2:0] F3_WORD  = 3'b010;
  localparam logic [2:0] F3_BYTEU = 3'b100;
  localparam logic [2:0] F3_HALFU = 3'b101;

  localparam logic [1:0] RS_ALU = 2'b00;
  localparam logic [1:0] RS_MEM = 2'b01;
  localparam logic [1:0] RS_PC4 = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  result_src;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [31:0] pc_plus4;
  } w_stage_t;

endpackage

// File: rtl/load_store_align.sv
// Combinational lane logic: size/alignment decode, store byte enables and lane
// replication, load lane extraction with sign or zero extension.
module load_store_align
  import memory_access_unit_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic        is_store_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic        size_ok_o,
  output logic        aligned_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = rdata_i[{offset_i, 3'b000} +: 8];
  assign half_lane = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    size_ok_o   = 1'b0;
    aligned_o   = 1'b0;
    be_o        = 4'b0000;
    wdata_o     = store_data_i;
    load_data_o = 32'h0;
    case (funct3_i)
      F3_BYTE: begin
        size_ok_o   = 1'b1;
        aligned_o   = 1'b1;
        load_data_o = {{24{byte_lane[7]}}, byte_lane};
      end
      F3_HALF: begin
        size_ok_o   = 1'b1;
        aligned_o   = ~offset_i[0];
        load_data_o = {{16{half_lane[15]}}, half_lane};
      end
      F3_WORD: begin
        size_ok_o   = 1'b1;
        aligned_o   = (offset_i == 2'b00);
        load_data_o = rdata_i;
      end
      F3_BYTEU: begin
        size_ok_o   = ~is_store_i;
        aligned_o   = 1'b1;
        load_data_o = {24'h0, byte_lane};
      end
      F3_HALFU: begin
        size_ok_o   = ~is_store_i;
        aligned_o   = ~offset_i[0];
        load_data_o = {16'h0, half_lane};
      end
      default: ;
    endcase

    // Stores drive the data on every lane of its size; the enables pick the lanes.
    if (is_store_i) begin
      case (funct3_i[1:0])
        2'b00: begin
          be_o    = 4'b0001 << offset_i;
          wdata_o = {4{store_data_i[7:0]}};
        end
        2'b01: begin
          be_o    = 4'b0011 << offset_i;
          wdata_o = {2{store_data_i[15:0]}};
        end
        default: be_o = 4'b1111;
      endcase
    end
  end

endmodule

// File: rtl/memory_access_unit.sv
// Pipeline memory stage: drives the data-memory handshake, stalls on wait states,
// abandons accesses after TIMEOUT cycles and feeds the memory/writeback register.
module memory_access_unit
  import memory_access_unit_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite_M,
  input  logic        MemWrite_M,
  input  logic [1:0]  ResultSrc_M,
  input  logic [4:0]  RD_M,
  input  logic [2:0]  funct3_M,
  input  logic [31:0] ALU_Result_M,
  input  logic [31:0] WriteData_M,
  input  logic [31:0] PCPlus4_M,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_M,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        RegWrite_W,
  output logic [1:0]  ResultSrc_W,
  output logic [4:0]  RD_W,
  output logic [31:0] ALU_Result_W,
  output logic [31:0] ReadData_W,
  output logic [31:0] PCPlus4_W
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  w_stage_t         w_q, w_d;
  logic             misalign_q, misalign_d;

  logic        is_store, is_load, access, size_ok, aligned, legal;
  logic [31:0] load_data;

  // A store flag wins over a memory result select.
  assign is_store = MemWrite_M;
  assign is_load  = (ResultSrc_M == RS_MEM) & ~MemWrite_M;
  assign access   = is_store | is_load;

  load_store_align u_align (
    .funct3_i     (funct3_M),
    .offset_i     (ALU_Result_M[1:0]),
    .is_store_i   (is_store),
    .store_data_i (WriteData_M),
    .rdata_i      (mem_rdata),
    .size_ok_o    (size_ok),
    .aligned_o    (aligned),
    .be_o         (mem_be),
    .wdata_o      (mem_wdata),
    .load_data_o  (load_data)
  );

  assign legal      = size_ok & aligned;
  assign misalign_d = access & ~legal & (state_q != ST_ERR);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_q holds the number of wait cycles already spent on the current access.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (mem_req && !mem_ack) begin
          state_d = ST_WAIT;
          cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_WAIT: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        if (mem_ack)                state_d = ST_IDLE;
        else if (cnt_q >= CNT_LAST) state_d = ST_ERR;
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req  = access & legal & (state_q != ST_ERR);
    mem_we   = is_store;
    mem_addr = {ALU_Result_M[31:2], 2'b00};
    stall_M  = mem_req & ~mem_ack;
    bus_err  = (state_q == ST_ERR);
  end

  // Stalls insert a bubble and hold; dropped accesses advance with RegWrite cleared.
  always_comb begin
    w_d = w_q;
    if (stall_M) begin
      w_d.reg_write = 1'b0;
    end else begin
      w_d.reg_write  = RegWrite_M & ~misalign_d & (state_q != ST_ERR);
      w_d.result_src = ResultSrc_M;
      w_d.rd         = RD_M;
      w_d.alu_result = ALU_Result_M;
      w_d.pc_plus4   = PCPlus4_M;
    end
    if (mem_req && mem_ack && is_load) w_d.read_data = load_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_q        <= '0;
      misalign_q <= 1'b0;
    end else begin
      w_q        <= w_d;
      misalign_q <= misalign_d;
    end
  end

  assign misalign_err = misalign_q;
  assign RegWrite_W   = w_q.reg_write;
  assign ResultSrc_W  = w_q.result_src;
  assign RD_W         = w_q.rd;
  assign ALU_Result_W = w_q.alu_result;
  assign ReadData_W   = w_q.read_data;
  assign PCPlus4_W    = w_q.pc_plus4;

endmodule

// File: tb/tb_memory_access_unit.sv
// Scoreboard bench for memory_access_unit: each instruction pushes its expected
// writeback result, which is popped and compared once the W register captures it.
module tb_memory_access_unit;
  import memory_access_unit_pkg::*;

  localparam int TIMEOUT = 16;

  logic        clk, rst;
  logic        RegWrite_M, MemWrite_M;
  logic [1:0]  ResultSrc_M;
  logic [4:0]  RD_M;
  logic [2:0]  funct3_M;
  logic [31:0] ALU_Result_M, WriteData_M, PCPlus4_M;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        stall_M, misalign_err, bus_err;
  logic        RegWrite_W;
  logic [1:0]  ResultSrc_W;
  logic [4:0]  RD_W;
  logic [31:0] ALU_Result_W, ReadData_W, PCPlus4_W;

  memory_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .RegWrite_M(RegWrite_M), .MemWrite_M(MemWrite_M), .ResultSrc_M(ResultSrc_M),
    .RD_M(RD_M), .funct3_M(funct3_M), .ALU_Result_M(ALU_Result_M),
    .WriteData_M(WriteData_M), .PCPlus4_M(PCPlus4_M),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_M(stall_M), .misalign_err(misalign_err), .bus_err(bus_err),
    .RegWrite_W(RegWrite_W), .ResultSrc_W(ResultSrc_W), .RD_W(RD_W),
    .ALU_Result_W(ALU_Result_W), .ReadData_W(ReadData_W), .PCPlus4_W(PCPlus4_W)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        reg_write;
    logic        dropped;
    logic [1:0]  result_src;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] read_data;
    logic [31:0] pc4;
    logic        misalign;
  } exp_w_t;

  exp_w_t      sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model_rd = 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int size_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  task automatic do_op(input string tag, input logic rw, input logic mw,
                       input logic [1:0] rs, input logic [4:0] rd, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rdata, input int ack_delay);
    logic        st, ld, acc, lgl, exp_req, tmo;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata, exp_load, sh;
    int          n, off, exp_stall;
    exp_w_t      e;

    st  = mw;
    ld  = (rs == 2'b01) && !mw;
    acc = st || ld;
    n   = size_bytes(f3);
    off = int'(addr[1:0]);
    lgl = (st ? (f3 inside {3'b000, 3'b001, 3'b010})
              : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) && ((off % n) == 0);
    exp_req = acc && lgl;

    exp_be = 4'b0000;
    exp_wdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (st && i >= off && i < off + n) exp_be[i] = 1'b1;
      exp_wdata[8*i +: 8] = wd[8*(i % n) +: 8];
    end
    sh = rdata >> (8 * off);
    if (n == 1)      exp_load = {{24{sh[7] & ~f3[2]}}, sh[7:0]};
    else if (n == 2) exp_load = {{16{sh[15] & ~f3[2]}}, sh[15:0]};
    else             exp_load = rdata;

    tmo       = exp_req && (ack_delay < 0);
    exp_stall = !exp_req ? 0 : (ack_delay < 0 ? TIMEOUT : ack_delay);

    if (ld && exp_req && !tmo) model_rd = exp_load;
    e.dropped    = tmo || (acc && !lgl);
    e.reg_write  = rw && !e.dropped;
    e.result_src = rs;
    e.rd         = rd;
    e.alu        = addr;
    e.read_data  = model_rd;
    e.pc4        = addr ^ 32'hA5A5_0000;
    e.misalign   = acc && !lgl;
    sb.push_back(e);

    RegWrite_M = rw;  MemWrite_M = mw;  ResultSrc_M = rs;  RD_M = rd;  funct3_M = f3;
    ALU_Result_M = addr;  WriteData_M = wd;  PCPlus4_M = addr ^ 32'hA5A5_0000;
    mem_rdata = rdata;
    mem_ack   = (ack_delay == 0);

    @(negedge clk);
    check({tag, "_req"}, 32'(mem_req), 32'(exp_req));
    if (exp_req) begin
      check({tag, "_addr"}, mem_addr, {addr[31:2], 2'b00});
      check({tag, "_we"}, 32'(mem_we), 32'(st));
      check({tag, "_be"}, 32'(mem_be), 32'(exp_be));
      if (st) check({tag, "_wdata"}, mem_wdata, exp_wdata);
    end

    for (int c = 0; c < exp_stall; c++) begin
      check({tag, "_stall"}, 32'(stall_M), 32'd1);
      @(posedge clk); #1;
      check({tag, "_bubble"}, 32'(RegWrite_W), 32'd0);
      if (c + 1 == ack_delay) mem_ack = 1'b1;
      @(negedge clk);
    end
    check({tag, "_nostall"}, 32'(stall_M), 32'd0);
    check({tag, "_bus_err"}, 32'(bus_err), 32'(tmo));
    if (tmo) check({tag, "_req_err"}, 32'(mem_req), 32'd0);

    @(posedge clk); #1;
    mem_ack = 1'b0;
    e = sb.pop_front();
    check({tag, "_W_regwrite"}, 32'(RegWrite_W), 32'(e.reg_write));
    check({tag, "_W_readdata"}, ReadData_W, e.read_data);
    check({tag, "_misalign"}, 32'(misalign_err), 32'(e.misalign));
    check({tag, "_bus_err_end"}, 32'(bus_err), 32'd0);
    if (!e.dropped) begin
      check({tag, "_W_rd"}, 32'(RD_W), 32'(e.rd));
      check({tag, "_W_alu"}, ALU_Result_W, e.alu);
      check({tag, "_W_rs"}, 32'(ResultSrc_W), 32'(e.result_src));
      check({tag, "_W_pc4"}, PCPlus4_W, e.pc4);
    end
  endtask

  task automatic check_w_zero(input string tag);
    check({tag, "_regwrite"}, 32'(RegWrite_W), 32'd0);
    check({tag, "_rs"}, 32'(ResultSrc_W), 32'd0);
    check({tag, "_rd"}, 32'(RD_W), 32'd0);
    check({tag, "_alu"}, ALU_Result_W, 32'd0);
    check({tag, "_readdata"}, ReadData_W, 32'd0);
    check({tag, "_pc4"}, PCPlus4_W, 32'd0);
    check({tag, "_misalign"}, 32'(misalign_err), 32'd0);
    check({tag, "_bus_err"}, 32'(bus_err), 32'd0);
  endtask

  task automatic zero_inputs();
    RegWrite_M = 1'b0;  MemWrite_M = 1'b0;  ResultSrc_M = 2'b00;  RD_M = 5'd0;
    funct3_M = 3'b000;  ALU_Result_M = 32'h0;  WriteData_M = 32'h0;  PCPlus4_M = 32'h0;
    mem_rdata = 32'h0;  mem_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    zero_inputs();
    #20;
    check_w_zero("reset");
    check("reset_stall", 32'(stall_M), 32'd0);
    #2 rst = 1'b1;
    @(posedge clk); #1;

    do_op("alu",     1, 0, RS_ALU, 5'd5,  3'b000,   32'h1234_5678, 32'h0,         32'h0,         0);
    do_op("sw",      0, 1, RS_ALU, 5'd0,  F3_WORD,  32'h0000_0104, 32'hDEAD_BEEF, 32'h0,         0);
    do_op("lb",      1, 0, RS_MEM, 5'd6,  F3_BYTE,  32'h0000_0103, 32'h0,         32'h80FF_0000, 3);
    do_op("lbu",     1, 0, RS_MEM, 5'd7,  F3_BYTEU, 32'h0000_0103, 32'h0,         32'h80FF_0000, 2);
    do_op("sh",      0, 1, RS_ALU, 5'd0,  F3_HALF,  32'h0000_0102, 32'h0000_1234, 32'h0,         1);
    do_op("lw_mis",  1, 0, RS_MEM, 5'd8,  F3_WORD,  32'h0000_0102, 32'h0,         32'h0,         0);
    do_op("lh",      1, 0, RS_MEM, 5'd9,  F3_HALF,  32'h0000_0102, 32'h0,         32'h8001_7FFF, 1);
    do_op("lhu",     1, 0, RS_MEM, 5'd10, F3_HALFU, 32'h0000_0100, 32'h0,         32'h8001_7FFF, 0);
    do_op("sb",      0, 1, RS_ALU, 5'd0,  F3_BYTE,  32'h0000_0101, 32'h0000_00AB, 32'h0,         0);
    do_op("ld_bad",  1, 0, RS_MEM, 5'd11, 3'b011,   32'h0000_0100, 32'h0,         32'h0,         0);
    do_op("st_bad",  0, 1, RS_ALU, 5'd0,  F3_BYTEU, 32'h0000_0100, 32'h0000_0055, 32'h0,         0);
    do_op("ld_st",   1, 1, RS_MEM, 5'd12, F3_WORD,  32'h0000_0208, 32'hCAFE_F00D, 32'h1111_2222, 0);
    do_op("lw_tmo",  1, 0, RS_MEM, 5'd13, F3_WORD,  32'h0000_0200, 32'h0,         32'h5555_5555, -1);
    do_op("lw_last", 1, 0, RS_MEM, 5'd14, F3_WORD,  32'h0000_0204, 32'h0,         32'h7654_3210, TIMEOUT - 1);
    do_op("jal",     1, 0, RS_PC4, 5'd1,  3'b000,   32'h0000_4000, 32'h0,         32'h0,         0);
    do_op("alu_pre", 1, 0, RS_ALU, 5'd3,  3'b000,   32'h0BAD_F00D, 32'h0,         32'h0,         0);

    // Reset arriving in the second wait cycle of a load that is never acknowledged.
    RegWrite_M = 1'b1;  MemWrite_M = 1'b0;  ResultSrc_M = RS_MEM;  RD_M = 5'd15;
    funct3_M = F3_WORD;  ALU_Result_M = 32'h300;  PCPlus4_M = 32'h304;  mem_ack = 1'b0;
    @(negedge clk);
    check("rstw_stall", 32'(stall_M), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rstw_in_wait", 32'(stall_M), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_w_zero("rstw");
    zero_inputs();
    model_rd = 32'h0;
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstw_req", 32'(mem_req), 32'd0);
    check("rstw_stall_after", 32'(stall_M), 32'd0);
    check("rstw_state", 32'(dut.state_q), 32'(ST_IDLE));
    @(posedge clk); #1;

    do_op("alu_post", 1, 0, RS_ALU, 5'd4, 3'b000, 32'h0000_0042, 32'h0, 32'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
